// File: rtl/pwm_multi_pkg.sv
// rtl/pwm_multi_pkg.sv - mode and count-direction encodings for the multi-channel PWM
package pwm_multi_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one duty comparator with double-buffered duty and registered output
module pwm_channel
    import pwm_multi_pkg::*;
#(
    parameter int   WIDTH = 8,
    parameter logic POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    input  logic             dir,
    input  logic             mute,
    input  logic             boundary,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm
);

    logic [WIDTH-1:0] duty_s;
    logic             active;

    // The down phase uses <= so the pulse mirrors the up phase about the period start.
    always_comb begin
        active = 1'b0;
        if (!mute) begin
            active = (dir == DIR_DOWN) ? (cnt <= duty_s) : (cnt < duty_s);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_s <= '0;
            pwm    <= POL;
        end else begin
            if (!en || boundary) begin
                duty_s <= duty;
            end
            pwm <= en ? (active ^ POL) : POL;
        end
    end

endmodule

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - reset synchroniser, shared period counter and boundary generation
module pwm_timebase
    import pwm_multi_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] top,
    output logic             rst_sync,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             boundary,
    output logic             mute
);

    logic [1:0]       sync_q;
    logic [WIDTH-1:0] top_s;
    logic             mode_s;

    // Assert immediately, release on the second clock after arst falls.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rst_sync = sync_q[1];

    always_comb begin
        boundary = 1'b0;
        if (top_s == '0) begin
            boundary = 1'b1;
        end else if (mode_s == MODE_EDGE) begin
            boundary = (cnt == top_s);
        end else begin
            boundary = (dir == DIR_DOWN) && (cnt == WIDTH'(1));
        end
    end

    // A zero-length centre period has no up or down phase, so nothing may fire.
    assign mute = (mode_s == MODE_CENTER) && (top_s == '0);

    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            cnt    <= '0;
            dir    <= DIR_UP;
            top_s  <= '0;
            mode_s <= MODE_EDGE;
        end else if (!en || boundary) begin
            cnt    <= '0;
            dir    <= DIR_UP;
            top_s  <= top;
            mode_s <= mode;
        end else if (mode_s == MODE_EDGE) begin
            cnt <= cnt + WIDTH'(1);
        end else if (dir == DIR_UP) begin
            cnt <= cnt + WIDTH'(1);
            if (cnt == top_s - WIDTH'(1)) begin
                dir <= DIR_DOWN;
            end
        end else begin
            cnt <= cnt - WIDTH'(1);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM sharing one period counter across CHANNELS comparators
module pwm_multi #(
    parameter int                  WIDTH    = 8,
    parameter int                  CHANNELS = 4,
    parameter logic [CHANNELS-1:0] POLARITY = {CHANNELS{1'b0}}
) (
    input  logic                      CLK,
    input  logic                      aRSTin,
    input  logic                      EN,
    input  logic                      MODE,
    input  logic [WIDTH-1:0]          TOP,
    input  logic [CHANNELS*WIDTH-1:0] Din,
    output logic [CHANNELS-1:0]       PWM,
    output logic                      PERIOD_END
);

    logic             rst_sync;
    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic             boundary;
    logic             mute;

    pwm_timebase #(
        .WIDTH(WIDTH)
    ) u_timebase (
        .clk      (CLK),
        .arst     (aRSTin),
        .en       (EN),
        .mode     (MODE),
        .top      (TOP),
        .rst_sync (rst_sync),
        .cnt      (cnt),
        .dir      (dir),
        .boundary (boundary),
        .mute     (mute)
    );

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        pwm_channel #(
            .WIDTH (WIDTH),
            .POL   (POLARITY[k])
        ) u_ch (
            .clk      (CLK),
            .rst      (rst_sync),
            .en       (EN),
            .cnt      (cnt),
            .dir      (dir),
            .mute     (mute),
            .boundary (boundary),
            .duty     (Din[k*WIDTH +: WIDTH]),
            .pwm      (PWM[k])
        );
    end

    // Registered alongside PWM so the strobe lines up with the last count's output.
    always_ff @(posedge CLK or posedge rst_sync) begin
        if (rst_sync) begin
            PERIOD_END <= 1'b0;
        end else begin
            PERIOD_END <= EN && boundary;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi against a period-position model
module tb_pwm_multi;

    localparam logic [3:0] POL = 4'b0101;

    logic        CLK = 1'b0;
    logic        aRSTin = 1'b0;
    logic        EN = 1'b0;
    logic        MODE = 1'b0;
    logic [7:0]  TOP = 8'd0;
    logic [31:0] Din = 32'd0;
    logic [3:0]  PWM;
    logic        PERIOD_END;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pwm_multi #(
        .WIDTH    (8),
        .CHANNELS (4),
        .POLARITY (POL)
    ) dut (
        .CLK        (CLK),
        .aRSTin     (aRSTin),
        .EN         (EN),
        .MODE       (MODE),
        .TOP        (TOP),
        .Din        (Din),
        .PWM        (PWM),
        .PERIOD_END (PERIOD_END)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: tracks position within the period rather than a counter/direction pair.
    bit         m_rst = 1'b1;
    int         m_rel = 0;
    int         m_pos = 0;
    int         ms_top = 0;
    bit         ms_mode = 1'b0;
    int         ms_d [4];
    logic [3:0] exp_pwm = POL;
    logic       exp_pe = 1'b0;
    bit         chk_on = 1'b0;

    function automatic void load_shadows();
        ms_top  = int'(TOP);
        ms_mode = MODE;
        for (int k = 0; k < 4; k++) ms_d[k] = int'(Din[k*8 +: 8]);
    endfunction

    always @(posedge CLK) begin
        if (aRSTin || m_rst) begin
            if (aRSTin) begin
                m_rst = 1'b1;
                m_rel = 0;
            end else begin
                m_rel++;
                if (m_rel == 2) m_rst = 1'b0;
            end
            m_pos   = 0;
            ms_top  = 0;
            ms_mode = 1'b0;
            for (int k = 0; k < 4; k++) ms_d[k] = 0;
            exp_pwm = POL;
            exp_pe  = 1'b0;
        end else if (!EN) begin
            load_shadows();
            m_pos   = 0;
            exp_pwm = POL;
            exp_pe  = 1'b0;
        end else begin
            bit         last;
            logic [3:0] nxt;
            for (int k = 0; k < 4; k++) begin
                bit act;
                if (ms_top == 0)         act = !ms_mode && (ms_d[k] > 0);
                else if (!ms_mode)       act = m_pos < ms_d[k];
                else if (m_pos < ms_top) act = m_pos < ms_d[k];
                else                     act = (2*ms_top - m_pos) <= ms_d[k];
                nxt[k] = act ^ POL[k];
            end
            if (ms_top == 0)  last = 1'b1;
            else if (!ms_mode) last = (m_pos == ms_top);
            else              last = (m_pos == 2*ms_top - 1);
            exp_pwm = nxt;
            exp_pe  = last;
            if (last) begin
                m_pos = 0;
                load_shadows();
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            check("pwm", {28'd0, PWM}, {28'd0, exp_pwm});
            check("period_end", {31'd0, PERIOD_END}, {31'd0, exp_pe});
        end
    end

    int acc_act [4];
    int acc_pe;

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic sample(input int n, input bit clear);
        if (clear) begin
            for (int k = 0; k < 4; k++) acc_act[k] = 0;
            acc_pe = 0;
        end
        repeat (n) begin
            @(negedge CLK);
            #1;
            for (int k = 0; k < 4; k++) acc_act[k] += int'(PWM[k] ^ POL[k]);
            acc_pe += int'(PERIOD_END);
        end
    endtask

    task automatic wait_pe(input int bound, output int n);
        bit found = 1'b0;
        n = 0;
        while (!found && n < bound) begin
            @(negedge CLK);
            #1;
            n++;
            found = PERIOD_END;
        end
        check("pe_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic set_duty(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        Din = {d3, d2, d1, d0};
    endtask

    initial begin
        int n;
        #1 aRSTin = 1'b1;
        #1;
        check("reset_pwm", {28'd0, PWM}, 32'h5);
        check("reset_pe", {31'd0, PERIOD_END}, 32'd0);
        step(2);
        chk_on = 1'b1;

        // Edge mode, TOP=9
        MODE = 1'b0;
        TOP  = 8'd9;
        set_duty(8'd3, 8'd0, 8'd10, 8'd255);
        EN = 1'b1;
        aRSTin = 1'b0;
        step(40);
        sample(10, 1'b1);
        check("edge_d3", acc_act[0], 3);
        check("edge_d0", acc_act[1], 0);
        check("edge_d10", acc_act[2], 10);
        check("edge_d255", acc_act[3], 10);
        check("edge_pe", acc_pe, 1);

        // Center mode, TOP=4
        MODE = 1'b1;
        TOP  = 8'd4;
        set_duty(8'd1, 8'd3, 8'd4, 8'd0);
        step(30);
        sample(8, 1'b1);
        check("ctr_d1", acc_act[0], 2);
        check("ctr_d3", acc_act[1], 6);
        check("ctr_d4", acc_act[2], 8);
        check("ctr_d0", acc_act[3], 0);
        check("ctr_pe", acc_pe, 1);

        // Duty change mid-period
        MODE = 1'b0;
        TOP  = 8'd9;
        set_duty(8'd3, 8'd0, 8'd10, 8'd255);
        step(25);
        wait_pe(30, n);
        sample(6, 1'b1);
        set_duty(8'd7, 8'd0, 8'd10, 8'd255);
        sample(4, 1'b0);
        check("duty_old_period", acc_act[0], 3);
        sample(10, 1'b1);
        check("duty_new_period", acc_act[0], 7);
        check("duty_new_pe", acc_pe, 1);

        // TOP reduced below current count
        TOP = 8'd200;
        wait_pe(30, n);
        step(51);
        TOP = 8'd10;
        wait_pe(300, n);
        check("top_cut_rest", n, 150);
        wait_pe(300, n);
        check("top_cut_next", n, 11);

        // Reset mid-run
        aRSTin = 1'b1;
        #1;
        check("rst_async_pwm", {28'd0, PWM}, 32'h5);
        check("rst_async_pe", {31'd0, PERIOD_END}, 32'd0);
        step(3);
        aRSTin = 1'b0;
        step(1);
        check("rst_rel1_pe", {31'd0, PERIOD_END}, 32'd0);
        step(1);
        check("rst_rel2_pe", {31'd0, PERIOD_END}, 32'd0);
        step(1);
        check("rst_rel3_pe", {31'd0, PERIOD_END}, 32'd1);
        check("rst_rel3_pwm", {28'd0, PWM}, 32'h5);

        // EN low for 5 cycles, then run TOP=3, D0=2
        EN   = 1'b0;
        MODE = 1'b0;
        TOP  = 8'd3;
        set_duty(8'd2, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("en_low_pwm", {28'd0, PWM}, 32'h5);
        end
        EN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("en_pattern", {31'd0, PWM[0] ^ POL[0]}, ((i % 4) < 2) ? 32'd1 : 32'd0);
        end

        // Randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4)  EN = ($urandom_range(0, 3) != 0);
            if (r < 10) TOP = 8'($urandom_range(0, 12));
            if (r < 15) MODE = 1'($urandom_range(0, 1));
            if (r < 30) set_duty(8'($urandom_range(0, 14)), 8'($urandom_range(0, 14)),
                                 8'($urandom_range(0, 14)), 8'($urandom_range(0, 255)));
            if (r == 99) begin
                aRSTin = 1'b1;
                step(2);
                aRSTin = 1'b0;
            end
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
